// File: rtl/cpu_core_mc.sv
// Multi-cycle CPU core: NREGS x DW register file, FETCH/DECODE/EXEC/MEM/WB FSM.
// Define CPU_MUL_EN to make opcode D a single-cycle MUL; otherwise it is a NOP.
module cpu_core_mc #(
  parameter int DW    = 8,
  parameter int AW    = 8,
  parameter int NREGS = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [15:0]   imem_rdata,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [AW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          carry,
  output logic          negative,
  output logic          halted,
  output logic [AW-1:0] pc
);
  localparam int RW = $clog2(NREGS);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   ir_q, ir_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [DW-1:0] wb_q, wb_d, res_q, res_d;
  logic          z_q, z_d, c_q, c_d, n_q, n_d;
  logic [DW-1:0] regs_q [NREGS];
  logic [DW-1:0] regs_d [NREGS];

  logic [3:0]       op;
  logic [RW-1:0]    rd_i, rs_i, rt_i;
  logic [DW+AW+7:0] imm_ext;
  logic [DW+AW-1:0] addr_ext;
  logic             mul_en;
  logic             is_alu, is_ldi, is_mem, is_bz, is_jmp, is_halt;
  logic [DW-1:0]    alu_res;
  logic             alu_c;
  logic [DW:0]      sum, diff;
  logic [2*DW-1:0]  prod;
  logic             unused;

`ifdef CPU_MUL_EN
  assign mul_en = 1'b1;
`else
  assign mul_en = 1'b0;
`endif

  assign op       = ir_q[15:12];
  assign rd_i     = ir_q[8 +: RW];
  assign rs_i     = ir_q[4 +: RW];
  assign rt_i     = ir_q[0 +: RW];
  assign imm_ext  = {{(DW+AW){1'b0}}, ir_q[7:0]};
  assign addr_ext = {{AW{1'b0}}, a_q};
  assign unused   = ^{ir_q, imm_ext, addr_ext};

  assign is_alu  = (op >= 4'h1 && op <= 4'h7) || (op == 4'hD && mul_en);
  assign is_ldi  = op == 4'h8;
  assign is_mem  = op == 4'h9 || op == 4'hA;
  assign is_bz   = op == 4'hB;
  assign is_jmp  = op == 4'hC;
  assign is_halt = op == 4'hF;

  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
    prod    = {{DW{1'b0}}, a_q} * {{DW{1'b0}}, b_q};
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      4'h1: {alu_c, alu_res} = sum;
      4'h2: {alu_c, alu_res} = diff;
      4'h3: alu_res = a_q & b_q;
      4'h4: alu_res = a_q | b_q;
      4'h5: alu_res = a_q ^ b_q;
      4'h6: {alu_c, alu_res} = {a_q, 1'b0};
      4'h7: {alu_res, alu_c} = {1'b0, a_q};
      4'hD: begin
        alu_res = prod[DW-1:0];
        alu_c   = |prod[2*DW-1:DW];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    wb_d    = wb_q;
    res_d   = res_q;
    z_d     = z_q;
    c_d     = c_q;
    n_d     = n_q;
    regs_d  = regs_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + AW'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = regs_q[rs_i];
        b_d     = regs_q[rt_i];
        s_d     = regs_q[rd_i];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        unique case (1'b1)
          is_alu: begin
            wb_d    = alu_res;
            z_d     = alu_res == '0;
            c_d     = alu_c;
            n_d     = alu_res[DW-1];
            state_d = S_WB;
          end
          is_ldi: begin
            wb_d    = imm_ext[DW-1:0];
            state_d = S_WB;
          end
          is_mem: state_d = S_MEM;
          is_bz: begin
            if (z_q) pc_d = imm_ext[AW-1:0];
            state_d = S_FETCH;
          end
          is_jmp: begin
            pc_d    = imm_ext[AW-1:0];
            state_d = S_FETCH;
          end
          is_halt: state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (op == 4'h9) begin
            wb_d    = dmem_rdata;
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        regs_d[rd_i] = wb_q;
        res_d        = wb_q;
        state_d      = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      wb_q    <= '0;
      res_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      wb_q    <= wb_d;
      res_q   <= res_d;
      z_q     <= z_d;
      c_q     <= c_d;
      n_q     <= n_d;
      regs_q  <= regs_d;
    end
  end

  // state resets to FETCH, so gate the fetch request while reset is held
  assign imem_req   = reset_n & (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign dmem_req   = state_q == S_MEM;
  assign dmem_we    = dmem_req & (op == 4'hA);
  assign dmem_addr  = addr_ext[AW-1:0];
  assign dmem_wdata = s_q;
  assign result     = res_q;
  assign zero       = z_q;
  assign carry      = c_q;
  assign negative   = n_q;
  assign halted     = state_q == S_HALT;
  assign pc         = pc_q;
endmodule
